// File: rtl/vga_fb_renderer.sv
// Pixel-output stage: maps the timing generator's raster position onto an upscaled
// framebuffer and drives registered RGB plus syncs re-aligned to the two-cycle pipeline.
module vga_fb_renderer #(
  parameter int H_W         = 10,
  parameter int V_W         = 10,
  parameter int FB_WIDTH    = 160,
  parameter int FB_HEIGHT   = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int COLOR_W     = 4,
  localparam int ADDR_W     = $clog2(FB_WIDTH*FB_HEIGHT),
  localparam int PIX_W      = 3*COLOR_W
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic [H_W-1:0]     hcount_i,
  input  logic [V_W-1:0]     vcount_i,
  input  logic               pixel_enable_i,
  input  logic               hs_i,
  input  logic               vs_i,
  input  logic               fb_we_i,
  input  logic [ADDR_W-1:0]  fb_waddr_i,
  input  logic [PIX_W-1:0]   fb_wdata_i,
  input  logic               border_we_i,
  input  logic [PIX_W-1:0]   border_i,
  output logic [COLOR_W-1:0] vga_r_o,
  output logic [COLOR_W-1:0] vga_g_o,
  output logic [COLOR_W-1:0] vga_b_o,
  output logic               vga_hs_o,
  output logic               vga_vs_o,
  output logic               frame_start_o,
  output logic               wr_err_o
);

  localparam int DEPTH = FB_WIDTH*FB_HEIGHT;

  logic [PIX_W-1:0] mem [DEPTH];

  logic [31:0]       fx, fy;
  logic              wr_ok;
  logic [ADDR_W-1:0] raddr_d, raddr_q;
  logic              in_fb_d, in_fb_q;
  logic              pe1_d, pe1_q;
  logic              hs1_d, hs1_q, vs1_d, vs1_q;
  logic [PIX_W-1:0]  rgb_d, rgb_q;
  logic              hs2_d, hs2_q, vs2_d, vs2_q;
  logic              frame_start_d, frame_start_q;
  logic              wr_err_d, wr_err_q;
  logic [PIX_W-1:0]  border_pend_d, border_pend_q;
  logic [PIX_W-1:0]  border_d, border_q;

  // S1: framebuffer coordinates; off-image positions read address 0 and show the border
  always_comb begin
    fx      = 32'(hcount_i >> SCALE_SHIFT);
    fy      = 32'(vcount_i >> SCALE_SHIFT);
    in_fb_d = (fx < 32'(FB_WIDTH)) && (fy < 32'(FB_HEIGHT));
    raddr_d = in_fb_d ? ADDR_W'(fy * 32'(FB_WIDTH) + fx) : '0;
    pe1_d   = pixel_enable_i;
    hs1_d   = hs_i;
    vs1_d   = vs_i;
  end

  // S2: the memory read lands straight in the output register, so the mux adds no cycle
  always_comb begin
    rgb_d = '0;
    if (pe1_q) begin
      rgb_d = in_fb_q ? mem[raddr_q] : border_q;
    end
    hs2_d         = hs1_q;
    vs2_d         = vs1_q;
    frame_start_d = (hcount_i == '0) && (vcount_i == '0);
    border_pend_d = border_we_i ? border_i : border_pend_q;
    border_d      = frame_start_q ? border_pend_q : border_q;
    wr_ok         = ({1'b0, fb_waddr_i} < (ADDR_W+1)'(DEPTH));
    wr_err_d      = wr_err_q | (fb_we_i & ~wr_ok);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      raddr_q       <= '0;
      in_fb_q       <= 1'b0;
      pe1_q         <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      rgb_q         <= '0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
      border_pend_q <= '0;
      border_q      <= '0;
    end else begin
      raddr_q       <= raddr_d;
      in_fb_q       <= in_fb_d;
      pe1_q         <= pe1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      rgb_q         <= rgb_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      frame_start_q <= frame_start_d;
      wr_err_q      <= wr_err_d;
      border_pend_q <= border_pend_d;
      border_q      <= border_d;
    end
  end

  // Unreset storage; the read above samples before this write, giving read-first collisions
  always_ff @(posedge clk_i) begin
    if (fb_we_i && wr_ok) begin
      mem[fb_waddr_i] <= fb_wdata_i;
    end
  end

  assign vga_r_o       = rgb_q[PIX_W-1 -: COLOR_W];
  assign vga_g_o       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b_o       = rgb_q[COLOR_W-1:0];
  assign vga_hs_o      = hs2_q;
  assign vga_vs_o      = vs2_q;
  assign frame_start_o = frame_start_q;
  assign wr_err_o      = wr_err_q;

endmodule
